// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters: port 0 (EX stage)
//   and port 1 (branch/address unit). Round-robin arbitration selects which
//   request drives the ALU. The ALU result, a locally computed zero flag and
//   the owning requester ID are captured in a one-entry response buffer with
//   a valid/ready handshake.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o  request handshake for port N (N = 0, 1)
//   reqN_data1_i / reqN_data2_i  operands for port N
//   reqN_ctrl_i                  ALU control code for port N
//   alu_data1_o / alu_data2_o    operands driven to the ALU
//   alu_ctrl_o                   control code driven to the ALU
//   alu_data_i                   combinational ALU result
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_data_o                   registered ALU result
//   rsp_zero_o                   registered (result == 0)
//   rsp_id_o                     requester that owns the response
//   busy_o                       response held while consumer stalls
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [WIDTH-1:0]  req0_data1_i,
    input  logic [WIDTH-1:0]  req0_data2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [WIDTH-1:0]  req1_data1_i,
    input  logic [WIDTH-1:0]  req1_data2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic [WIDTH-1:0]  alu_data1_o,
    output logic [WIDTH-1:0]  alu_data2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_zero_o,
    output logic              rsp_id_o,
    output logic              busy_o
);

    // Zero detect on the raw ALU result (independent of the ALU's own flag).
    function automatic logic f_is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    logic              r_last_grant;
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_id;

    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_can_accept;
    logic              w_accept;

    // The buffer may refill in the same cycle it drains; nothing is accepted in reset.
    assign w_can_accept = !rst_i && (!r_rsp_valid || rsp_ready_i);
    assign w_accept     = w_grant_valid && w_can_accept;

    // Round-robin grant: on contention the port that did not win last time goes.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_grant_valid = 1'b1;
            w_grant_id    = !r_last_grant;
        end else if (req0_valid_i) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b0;
        end else if (req1_valid_i) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b1;
        end else begin
            w_grant_valid = 1'b0;
            w_grant_id    = 1'b0;
        end
    end

    // ALU operand mux; with no grant port 0 is driven so the value is deterministic.
    always_comb begin
        alu_data1_o = req0_data1_i;
        alu_data2_o = req0_data2_i;
        alu_ctrl_o  = req0_ctrl_i;
        if (w_grant_valid && w_grant_id) begin
            alu_data1_o = req1_data1_i;
            alu_data2_o = req1_data2_i;
            alu_ctrl_o  = req1_ctrl_i;
        end else begin
            alu_data1_o = req0_data1_i;
            alu_data2_o = req0_data2_i;
            alu_ctrl_o  = req0_ctrl_i;
        end
    end

    assign req0_ready_o = w_accept && !w_grant_id;
    assign req1_ready_o = w_accept &&  w_grant_id;

    // Response buffer and priority pointer; the pointer moves only on an accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= {WIDTH{1'b0}};
            r_rsp_zero   <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= alu_data_i;
            r_rsp_zero   <= f_is_zero(alu_data_i);
            r_rsp_id     <= w_grant_id;
        end else if (rsp_ready_i) begin
            r_rsp_valid  <= 1'b0;
        end else begin
            r_rsp_valid  <= r_rsp_valid;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_zero_o  = r_rsp_zero;
    assign rsp_id_o    = r_rsp_id;
    assign busy_o      = r_rsp_valid && !rsp_ready_i;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req0_valid_i, req1_valid_i;
    logic              req0_ready_o, req1_ready_o;
    logic [WIDTH-1:0]  req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [CTRL_W-1:0] req0_ctrl_i, req1_ctrl_i;
    logic [WIDTH-1:0]  alu_data1_o, alu_data2_o, alu_data_i;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic              rsp_valid_o, rsp_ready_i, rsp_zero_o, rsp_id_o, busy_o;
    logic [WIDTH-1:0]  rsp_data_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    // Stand-in ALU: 001 add, 010 sub, otherwise AND.
    always_comb begin
        case (alu_ctrl_o)
            3'b001:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o - alu_data2_o;
            default: alu_data_i = alu_data1_o & alu_data2_o;
        endcase
    end

    alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .rsp_id_o(rsp_id_o),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance through a rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; rsp_ready_i = 1'b1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b0;
        req0_data1_i = 32'd5;  req0_data2_i = 32'd3; req0_ctrl_i = 3'b001;
        req1_data1_i = 32'd50; req1_data2_i = 32'd8; req1_ctrl_i = 3'b010;
        tick(); tick();
        // Reset: no acceptance while rst_i is high.
        chk("rst_ready0", {31'd0, req0_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_zero", {31'd0, rsp_zero_o}, 32'd0);
        chk("rst_id", {31'd0, rsp_id_o}, 32'd0);

        // Single request from port 0: 5 + 3.
        rst_i = 1'b0;
        #1;
        chk("single_ready0", {31'd0, req0_ready_o}, 32'd1);
        chk("single_ready1", {31'd0, req1_ready_o}, 32'd0);
        chk("single_alu_d1", alu_data1_o, 32'd5);
        tick();
        req0_valid_i = 1'b0;
        chk("single_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("single_data", rsp_data_o, 32'd8);
        chk("single_zero", {31'd0, rsp_zero_o}, 32'd0);
        chk("single_id", {31'd0, rsp_id_o}, 32'd0);
        // Drain with no new request: valid drops, data holds.
        tick();
        chk("drain_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("drain_data_hold", rsp_data_o, 32'd8);
        chk("idle_alu_port0", alu_data1_o, 32'd5);

        // Re-reset so port 0 wins the first contest.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        // Contention: port0 10+20=30, port1 50-8=42; grants 0,1,0,1.
        req0_data1_i = 32'd10; req0_data2_i = 32'd20; req0_ctrl_i = 3'b001;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_ready0", {31'd0, req0_ready_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_ready1", {31'd0, req1_ready_o}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("cont_id", {31'd0, rsp_id_o}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("cont_data", rsp_data_o, (k % 2 == 0) ? 32'd30 : 32'd42);
        end

        // Backpressure with a held response (id 1, 42); req1 is 0x1234-0x1234.
        req0_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        req1_data1_i = 32'h1234; req1_data2_i = 32'h1234; req1_ctrl_i = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready1", {31'd0, req1_ready_o}, 32'd0);
            chk("bp_busy", {31'd0, busy_o}, 32'd1);
            chk("bp_data", rsp_data_o, 32'd42);
            chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_release_ready1", {31'd0, req1_ready_o}, 32'd1);
        chk("bp_release_busy", {31'd0, busy_o}, 32'd0);
        tick();
        // Zero flag from a SUB of equal operands.
        chk("zero_flag", {31'd0, rsp_zero_o}, 32'd1);
        chk("zero_data", rsp_data_o, 32'd0);
        chk("zero_id", {31'd0, rsp_id_o}, 32'd1);

        // Priority freeze: make last grant 0 (port 0 alone: 5+3).
        req1_valid_i = 1'b0;
        req0_data1_i = 32'd5; req0_data2_i = 32'd3; req0_ctrl_i = 3'b001;
        req0_valid_i = 1'b1;
        tick();
        chk("pf_setup_id", {31'd0, rsp_id_o}, 32'd0);
        chk("pf_setup_data", rsp_data_o, 32'd8);
        rsp_ready_i = 1'b0;
        req1_data1_i = 32'd50; req1_data2_i = 32'd8;
        req1_valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("pf_stall_ready0", {31'd0, req0_ready_o}, 32'd0);
            chk("pf_stall_ready1", {31'd0, req1_ready_o}, 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("pf_release_ready1", {31'd0, req1_ready_o}, 32'd1);
        chk("pf_release_ready0", {31'd0, req0_ready_o}, 32'd0);
        tick();
        chk("pf_id", {31'd0, rsp_id_o}, 32'd1);
        chk("pf_data", rsp_data_o, 32'd42);

        // Reset mid-operation: pending response discarded, pointer restored.
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        chk("mid_pending", {31'd0, rsp_valid_o}, 32'd1);
        rst_i = 1'b1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        #1;
        chk("mid_rst_ready0", {31'd0, req0_ready_o}, 32'd0);
        chk("mid_rst_ready1", {31'd0, req1_ready_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        chk("mid_valid", {31'd0, rsp_valid_o}, 32'd0);
        rsp_ready_i = 1'b1;
        req0_data1_i = 32'd10; req0_data2_i = 32'd20;
        #1;
        chk("mid_ready0", {31'd0, req0_ready_o}, 32'd1);
        chk("mid_ready1", {31'd0, req1_ready_o}, 32'd0);
        tick();
        chk("mid_id", {31'd0, rsp_id_o}, 32'd0);
        chk("mid_data", rsp_data_o, 32'd30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
